// File: rtl/rv_plic_core.sv
// rtl/rv_plic_core.sv - per-source interrupt gateways with per-target priority arbiters
// Gateways latch level/edge requests; each target registers its highest-priority enabled source.
module rv_plic_core #(
  parameter int NumSrc    = 32,
  parameter int NumTarget = 2,
  parameter int MaxPrio   = 7,
  parameter int EdgeCntW  = 2,
  parameter int SrcW      = $clog2(NumSrc),
  parameter int PrioW     = $clog2(MaxPrio + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumSrc-1:0]           intr_src_i,
  input  logic [NumSrc-1:0]           le_i,
  input  logic [NumSrc*PrioW-1:0]     prio_i,
  input  logic [NumTarget*NumSrc-1:0] ie_i,
  input  logic [NumTarget*PrioW-1:0]  threshold_i,
  input  logic [NumTarget-1:0]        claim_re_i,
  input  logic [NumTarget-1:0]        complete_we_i,
  input  logic [NumTarget*SrcW-1:0]   complete_id_i,
  output logic [NumSrc-1:0]           ip_o,
  output logic [NumTarget-1:0]        irq_o,
  output logic [NumTarget*SrcW-1:0]   irq_id_o,
  output logic [NumSrc-1:0]           edge_ovf_o
);

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_ACTIVE  = 2'd2
  } gw_state_e;

  localparam logic [EdgeCntW-1:0] CntMax = {EdgeCntW{1'b1}};
  localparam logic [EdgeCntW-1:0] CntOne = EdgeCntW'(1);

  gw_state_e                 state_q [NumSrc];
  gw_state_e                 state_d [NumSrc];
  logic [EdgeCntW-1:0]       cnt_q   [NumSrc];
  logic [EdgeCntW-1:0]       cnt_d   [NumSrc];
  logic [NumSrc-1:0]         src_q, ovf_q, ovf_d;
  logic [NumSrc-1:0]         edge_det, claim_hit, complete_hit;
  logic [NumTarget-1:0]      irq_q, irq_d;
  logic [NumTarget*SrcW-1:0] irq_id_q, irq_id_d;

  assign edge_det = intr_src_i & ~src_q;

  // Strobes from several targets naming the same source collapse into one hit.
  always_comb begin : decode
    claim_hit    = '0;
    complete_hit = '0;
    for (int s = 0; s < NumSrc; s++) begin
      for (int t = 0; t < NumTarget; t++) begin
        if (claim_re_i[t] && irq_id_q[t*SrcW +: SrcW] == SrcW'(s)) claim_hit[s] = 1'b1;
        if (complete_we_i[t] && complete_id_i[t*SrcW +: SrcW] == SrcW'(s)) complete_hit[s] = 1'b1;
      end
    end
  end

  always_comb begin : gateway
    logic [EdgeCntW-1:0] cnt_upd;
    cnt_upd = '0;
    for (int s = 0; s < NumSrc; s++) begin
      state_d[s] = state_q[s];
      ovf_d[s]   = 1'b0;
      cnt_upd    = cnt_q[s];
      // The edge is counted before the complete decides whether to re-pend.
      if (le_i[s] && edge_det[s] && state_q[s] != GW_IDLE) begin
        if (cnt_q[s] == CntMax) ovf_d[s] = 1'b1;
        else                    cnt_upd  = cnt_q[s] + CntOne;
      end
      case (state_q[s])
        GW_IDLE:    if (le_i[s] ? edge_det[s] : intr_src_i[s]) state_d[s] = GW_PENDING;
        GW_PENDING: if (claim_hit[s]) state_d[s] = GW_ACTIVE;
        GW_ACTIVE: begin
          if (complete_hit[s]) begin
            if (le_i[s] && cnt_upd != '0) begin
              state_d[s] = GW_PENDING;
              cnt_upd    = cnt_upd - CntOne;
            end else begin
              state_d[s] = GW_IDLE;
            end
          end
        end
        default:    state_d[s] = GW_IDLE;
      endcase
      cnt_d[s] = le_i[s] ? cnt_upd : '0;
    end
    // ID 0 is reserved and never leaves IDLE.
    state_d[0] = GW_IDLE;
    cnt_d[0]   = '0;
    ovf_d[0]   = 1'b0;
  end

  // Strict '>' against the running best gives threshold filtering and lowest-ID tie-break.
  always_comb begin : arbiter
    logic [PrioW-1:0] best_prio;
    logic [SrcW-1:0]  best_id;
    irq_d     = '0;
    irq_id_d  = '0;
    best_prio = '0;
    best_id   = '0;
    for (int t = 0; t < NumTarget; t++) begin
      best_prio = threshold_i[t*PrioW +: PrioW];
      best_id   = '0;
      for (int s = 0; s < NumSrc; s++) begin
        if (state_q[s] == GW_PENDING && ie_i[t*NumSrc + s] &&
            prio_i[s*PrioW +: PrioW] > best_prio) begin
          best_prio = prio_i[s*PrioW +: PrioW];
          best_id   = SrcW'(s);
        end
      end
      irq_d[t]                   = (best_id != '0);
      irq_id_d[t*SrcW +: SrcW]   = best_id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NumSrc; s++) begin
        state_q[s] <= GW_IDLE;
        cnt_q[s]   <= '0;
      end
      src_q    <= '0;
      ovf_q    <= '0;
      irq_q    <= '0;
      irq_id_q <= '0;
    end else begin
      for (int s = 0; s < NumSrc; s++) begin
        state_q[s] <= state_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
      src_q    <= intr_src_i;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  always_comb begin : ip_decode
    ip_o = '0;
    for (int s = 0; s < NumSrc; s++) ip_o[s] = (state_q[s] == GW_PENDING);
  end

  assign irq_o      = irq_q;
  assign irq_id_o   = irq_id_q;
  assign edge_ovf_o = ovf_q;

endmodule

// File: tb/tb_rv_plic_core.sv
// tb/tb_rv_plic_core.sv - directed and randomized checks of rv_plic_core against a reference model
// The model tracks each gateway as an integer state/count and arbitrates by max-priority search.
module tb_rv_plic_core;

  localparam int NumSrc    = 32;
  localparam int NumTarget = 2;
  localparam int MaxPrio   = 7;
  localparam int EdgeCntW  = 2;
  localparam int SrcW      = $clog2(NumSrc);
  localparam int PrioW     = $clog2(MaxPrio + 1);
  localparam int CntMax    = (1 << EdgeCntW) - 1;
  localparam int ST_IDLE   = 0;
  localparam int ST_PEND   = 1;
  localparam int ST_ACT    = 2;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic [NumSrc-1:0]           intr_src;
  logic [NumSrc-1:0]           le;
  logic [NumSrc*PrioW-1:0]     prio;
  logic [NumTarget*NumSrc-1:0] ie;
  logic [NumTarget*PrioW-1:0]  thr;
  logic [NumTarget-1:0]        claim, cwe;
  logic [NumTarget*SrcW-1:0]   cid;
  logic [NumSrc-1:0]           ip_o, edge_ovf_o;
  logic [NumTarget-1:0]        irq_o;
  logic [NumTarget*SrcW-1:0]   irq_id_o;

  int n_checks = 0;
  int n_errors = 0;
  int ovf7_seen = 0;

  int m_st  [NumSrc];
  int m_cnt [NumSrc];
  bit m_prev[NumSrc];
  bit m_ovf [NumSrc];
  bit m_irq [NumTarget];
  int m_id  [NumTarget];

  rv_plic_core #(
    .NumSrc(NumSrc), .NumTarget(NumTarget), .MaxPrio(MaxPrio), .EdgeCntW(EdgeCntW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .intr_src_i(intr_src), .le_i(le), .prio_i(prio),
    .ie_i(ie), .threshold_i(thr), .claim_re_i(claim), .complete_we_i(cwe),
    .complete_id_i(cid), .ip_o(ip_o), .irq_o(irq_o), .irq_id_o(irq_id_o),
    .edge_ovf_o(edge_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int prio_of(input int s);
    return int'(prio[s*PrioW +: PrioW]);
  endfunction

  function automatic bit is_cand(input int t, input int s);
    return m_st[s] == ST_PEND && ie[t*NumSrc + s] && prio_of(s) > int'(thr[t*PrioW +: PrioW]);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NumSrc; s++) begin
      m_st[s] = ST_IDLE; m_cnt[s] = 0; m_prev[s] = 1'b0; m_ovf[s] = 1'b0;
    end
    for (int t = 0; t < NumTarget; t++) begin
      m_irq[t] = 1'b0; m_id[t] = 0;
    end
  endtask

  // One clock: predict from current model state and inputs, then compare after the edge.
  task automatic step();
    int n_st [NumSrc];
    int n_cnt[NumSrc];
    bit n_ovf[NumSrc];
    int n_id [NumTarget];
    logic [NumSrc-1:0]         e_ip, e_ovf;
    logic [NumTarget-1:0]      e_irq;
    logic [NumTarget*SrcW-1:0] e_id;
    for (int t = 0; t < NumTarget; t++) begin
      int maxp;
      maxp = 0;
      n_id[t] = 0;
      for (int s = 1; s < NumSrc; s++)
        if (is_cand(t, s) && prio_of(s) > maxp) maxp = prio_of(s);
      for (int s = NumSrc - 1; s >= 1; s--)
        if (is_cand(t, s) && prio_of(s) == maxp) n_id[t] = s;
    end
    for (int s = 0; s < NumSrc; s++) begin
      n_st[s] = m_st[s]; n_cnt[s] = m_cnt[s]; n_ovf[s] = 1'b0;
    end
    for (int s = 1; s < NumSrc; s++) begin
      bit rise, clm, cmp;
      rise = intr_src[s] && !m_prev[s];
      clm = 1'b0;
      cmp = 1'b0;
      for (int t = 0; t < NumTarget; t++) begin
        if (claim[t] && m_id[t] == s) clm = 1'b1;
        if (cwe[t] && int'(cid[t*SrcW +: SrcW]) == s) cmp = 1'b1;
      end
      if (le[s]) begin
        if (rise && m_st[s] != ST_IDLE) begin
          if (m_cnt[s] == CntMax) n_ovf[s] = 1'b1;
          else n_cnt[s] = m_cnt[s] + 1;
        end
        if (m_st[s] == ST_IDLE && rise) n_st[s] = ST_PEND;
        else if (m_st[s] == ST_PEND && clm) n_st[s] = ST_ACT;
        else if (m_st[s] == ST_ACT && cmp) begin
          if (n_cnt[s] > 0) begin n_st[s] = ST_PEND; n_cnt[s]--; end
          else n_st[s] = ST_IDLE;
        end
      end else begin
        n_cnt[s] = 0;
        if (m_st[s] == ST_IDLE && intr_src[s]) n_st[s] = ST_PEND;
        else if (m_st[s] == ST_PEND && clm) n_st[s] = ST_ACT;
        else if (m_st[s] == ST_ACT && cmp) n_st[s] = ST_IDLE;
      end
    end
    @(posedge clk_i);
    #1;
    for (int s = 0; s < NumSrc; s++) begin
      m_st[s] = n_st[s]; m_cnt[s] = n_cnt[s]; m_ovf[s] = n_ovf[s]; m_prev[s] = intr_src[s];
      e_ip[s]  = (m_st[s] == ST_PEND);
      e_ovf[s] = m_ovf[s];
    end
    for (int t = 0; t < NumTarget; t++) begin
      m_id[t]  = n_id[t];
      m_irq[t] = (n_id[t] != 0);
      e_irq[t] = m_irq[t];
      e_id[t*SrcW +: SrcW] = SrcW'(m_id[t]);
    end
    if (edge_ovf_o[7]) ovf7_seen++;
    check("ip", 64'(ip_o), 64'(e_ip));
    check("ovf", 64'(edge_ovf_o), 64'(e_ovf));
    check("irq", 64'(irq_o), 64'(e_irq));
    check("irq_id", 64'(irq_id_o), 64'(e_id));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic claim_now(input int t);
    claim[t] = 1'b1; step(); claim[t] = 1'b0;
  endtask

  task automatic complete_now(input int t, input int id);
    cwe[t] = 1'b1; cid[t*SrcW +: SrcW] = SrcW'(id); step(); cwe[t] = 1'b0;
  endtask

  task automatic pulse(input int s);
    intr_src[s] = 1'b1; step(); intr_src[s] = 1'b0; step();
  endtask

  task automatic drain(input int t);
    int id;
    for (int i = 0; i < 40; i++) begin
      if (m_irq[t]) begin
        id = m_id[t]; claim_now(t); complete_now(t, id);
      end else step();
    end
  endtask

  function automatic int id_of(input int t);
    return int'(irq_id_o[t*SrcW +: SrcW]);
  endfunction

  initial begin
    rst_ni = 1'b0; intr_src = '0; le = '0; prio = '0; ie = '0; thr = '0;
    claim = '0; cwe = '0; cid = '0;
    model_reset();
    @(posedge clk_i); #1;
    check("rst_ip", 64'(ip_o), 0);
    check("rst_irq", 64'(irq_o), 0);
    check("rst_id", 64'(irq_id_o), 0);
    check("rst_ovf", 64'(edge_ovf_o), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Level basic
    prio[3*PrioW +: PrioW] = 3'd2; ie[0*NumSrc + 3] = 1'b1; thr[0 +: PrioW] = 3'd1;
    intr_src[3] = 1'b1;
    step();
    check("lvl_ip3", 64'(ip_o[3]), 1);
    check("lvl_irq_early", 64'(irq_o[0]), 0);
    step();
    check("lvl_irq", 64'(irq_o[0]), 1);
    check("lvl_id", 64'(id_of(0)), 3);
    claim_now(0);
    check("lvl_claim_ip", 64'(ip_o[3]), 0);
    check("lvl_stale_id", 64'(id_of(0)), 3);
    step();
    check("lvl_id_cleared", 64'(id_of(0)), 0);
    complete_now(0, 3);
    check("lvl_cmp_ip", 64'(ip_o[3]), 0);
    step();
    check("lvl_repend", 64'(ip_o[3]), 1);
    intr_src[3] = 1'b0;
    drain(0);

    // Arbitration
    prio[5*PrioW +: PrioW] = 3'd4; prio[9*PrioW +: PrioW] = 3'd4; prio[2*PrioW +: PrioW] = 3'd3;
    ie[2] = 1'b1; ie[5] = 1'b1; ie[9] = 1'b1; thr[0 +: PrioW] = 3'd0;
    intr_src[2] = 1'b1; intr_src[5] = 1'b1; intr_src[9] = 1'b1;
    step();
    intr_src = '0;
    step();
    check("arb_id", 64'(id_of(0)), 5);
    thr[0 +: PrioW] = 3'd4;
    step();
    check("arb_thr_irq", 64'(irq_o[0]), 0);
    check("arb_thr_id", 64'(id_of(0)), 0);
    thr[0 +: PrioW] = 3'd0;
    drain(0);
    check("arb_drained", 64'(ip_o), 0);

    // Edge counting with saturation
    le[7] = 1'b1; prio[7*PrioW +: PrioW] = 3'd5; ie[7] = 1'b1;
    pulse(7);
    check("edge_id", 64'(id_of(0)), 7);
    claim_now(0);
    ovf7_seen = 0;
    for (int i = 0; i < 4; i++) pulse(7);
    check("edge_ovf_once", 64'(ovf7_seen), 1);
    for (int i = 0; i < 3; i++) begin
      complete_now(0, 7);
      check("edge_repend", 64'(ip_o[7]), 1);
      step();
      claim_now(0);
    end
    complete_now(0, 7);
    check("edge_final_idle", 64'(ip_o[7]), 0);
    idle(2);
    check("edge_stays_idle", 64'(ip_o[7]), 0);

    // Two targets claiming together
    prio[4*PrioW +: PrioW] = 3'd6; ie[0*NumSrc + 4] = 1'b1; ie[1*NumSrc + 4] = 1'b1;
    pulse(4);
    check("tt_id0", 64'(id_of(0)), 4);
    check("tt_id1", 64'(id_of(1)), 4);
    claim = 2'b11; step(); claim = '0;
    check("tt_claim_ip", 64'(ip_o[4]), 0);
    complete_now(1, 4);
    idle(2);
    check("tt_idle", 64'(ip_o[4]), 0);

    // Ignored operations
    prio[6*PrioW +: PrioW] = 3'd1;
    pulse(6);
    complete_now(0, 0);
    complete_now(0, 6);
    check("ign_cmp", 64'(ip_o[6]), 1);
    claim_now(1);
    check("ign_claim", 64'(ip_o[6]), 1);
    ie[6] = 1'b1;
    drain(0);

    // Reset mid-operation with ACTIVE source holding counted edges
    pulse(7);
    claim_now(0);
    pulse(7);
    pulse(7);
    rst_ni = 1'b0;
    #1;
    check("mrst_ip", 64'(ip_o), 0);
    check("mrst_irq", 64'(irq_o), 0);
    check("mrst_id", 64'(irq_id_o), 0);
    check("mrst_ovf", 64'(edge_ovf_o), 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    model_reset();
    idle(3);
    check("mrst_no_repend", 64'(ip_o), 0);

    // Randomized traffic
    for (int s = 0; s < NumSrc; s++) prio[s*PrioW +: PrioW] = PrioW'($urandom_range(0, MaxPrio));
    ie = {$urandom, $urandom};
    le = $urandom;
    for (int i = 0; i < 600; i++) begin
      int act[$];
      if (i % 97 == 0) begin
        le = $urandom;
        for (int t = 0; t < NumTarget; t++) thr[t*PrioW +: PrioW] = PrioW'($urandom_range(0, 3));
      end
      intr_src = $urandom & $urandom;
      act.delete();
      for (int s = 1; s < NumSrc; s++) if (m_st[s] == ST_ACT) act.push_back(s);
      for (int t = 0; t < NumTarget; t++) begin
        claim[t] = ($urandom_range(0, 2) == 0);
        cwe[t]   = ($urandom_range(0, 2) == 0);
        if (act.size() > 0 && $urandom_range(0, 3) != 0)
          cid[t*SrcW +: SrcW] = SrcW'(act[$urandom_range(0, act.size() - 1)]);
        else
          cid[t*SrcW +: SrcW] = SrcW'($urandom_range(0, NumSrc - 1));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
